// File: rtl/spi_cache_ctrl_pkg.sv
// cache_pkg: shared widths, FSM states and the request address layout for spi_cache_ctrl.
package cache_pkg;
  localparam int TAG_W = 15;
  localparam int IDX_W = 5;
  localparam int OFF_W = 3;
  typedef enum logic [2:0] {IDLE, LOOKUP, RESP, FILL_REQ, FILL, REREAD} cache_state_t;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
    logic             byte_off;
  } cache_addr_t;
endpackage

// File: rtl/spi_cache_ctrl_tag_store.sv
// cache_tag_store: per-line {valid, tag} flops with a combinational hit compare, one write port and clear-all.
module cache_tag_store
  import cache_pkg::*;
#(
  parameter int LINES = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr_all,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  logic             wvalid,
  input  logic [IDX_W-1:0] ridx,
  input  logic [TAG_W-1:0] rtag,
  output logic             hit
);
  logic [TAG_W:0] lines_q [LINES];
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N)
      for (int i = 0; i < LINES; i++) lines_q[i] <= '0;
    else if (clr_all)
      for (int i = 0; i < LINES; i++) lines_q[i][TAG_W] <= 1'b0;
    else if (we)
      lines_q[widx] <= {wvalid, wtag};
  assign hit = lines_q[ridx][TAG_W] && lines_q[ridx][TAG_W-1:0] == rtag;
endmodule

// File: rtl/spi_cache_ctrl.sv
// spi_cache_ctrl: direct-mapped read cache refilled from SPI flash in 8-word lines.
// Define CACHE_STATS_EN to build the saturating hit/miss counters.
module spi_cache_ctrl
  import cache_pkg::*;
#(
  parameter int LINES = 32,
  parameter int AW    = 24
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          rsp_valid,
  output logic [15:0]   rsp_data,
  input  logic          flush,
  output logic          fill_req,
  input  logic          fill_ack,
  output logic [AW-1:0] fill_addr,
  input  logic          fill_valid,
  input  logic [15:0]   fill_data,
  output logic          RAM_EN,
  output logic [1:0]    RAM_WE,
  output logic [7:0]    RAM_A,
  output logic [15:0]   RAM_DI,
  input  logic [15:0]   RAM_DO,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count
);
  cache_state_t     state;
  cache_addr_t      a_q;
  logic [OFF_W-1:0] cnt;
  logic             flush_pend, ram_en_q, hit, fill_wr, flush_now, tag_we, unused_byte;
  logic [7:0]       ram_a_q;
  assign unused_byte = a_q.byte_off;
  always_comb begin
    fill_wr   = state == FILL && fill_valid;
    flush_now = state == IDLE && (flush_pend || flush);
    req_ready = state == IDLE && !flush_pend && !flush;
    tag_we    = (state == LOOKUP && !hit) || (fill_wr && cnt == 3'd7);
    RAM_EN    = ram_en_q || fill_wr;
    RAM_WE    = fill_wr ? 2'b11 : 2'b00;
    RAM_A     = fill_wr ? {a_q.index, cnt} : ram_a_q;
    RAM_DI    = fill_wr ? fill_data : '0;
    rsp_data  = rsp_valid ? RAM_DO : '0;
  end
  cache_tag_store #(.LINES(LINES)) u_tags (
    .CLK(CLK), .RST_N(RST_N), .clr_all(flush_now), .we(tag_we),
    .widx(a_q.index), .wtag(a_q.tag), .wvalid(state == FILL),
    .ridx(a_q.index), .rtag(a_q.tag), .hit(hit)
  );
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state      <= IDLE;
      a_q        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      rsp_valid  <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_a_q    <= '0;
      fill_req   <= 1'b0;
      fill_addr  <= '0;
    end else begin
      ram_en_q   <= 1'b0;
      rsp_valid  <= 1'b0;
      flush_pend <= state != IDLE && (flush_pend || flush);
      case (state)
        IDLE:
          if (req_valid && req_ready) begin
            a_q      <= cache_addr_t'(req_addr);
            ram_en_q <= 1'b1;
            ram_a_q  <= req_addr[8:1];
            state    <= LOOKUP;
          end
        LOOKUP:
          if (hit) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            fill_req  <= 1'b1;
            fill_addr <= AW'({a_q.tag, a_q.index, 4'b0});
            state     <= FILL_REQ;
          end
        RESP: state <= IDLE;
        FILL_REQ:
          if (fill_ack) begin
            fill_req <= 1'b0;
            cnt      <= '0;
            state    <= FILL;
          end
        FILL:
          if (fill_valid) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              ram_en_q <= 1'b1;
              ram_a_q  <= {a_q.index, a_q.offset};
              state    <= REREAD;
            end
          end
        REREAD: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef CACHE_STATS_EN
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      hit_count  <= hit_count + 16'(hit && hit_count != 16'hFFFF);
      miss_count <= miss_count + 16'(!hit && miss_count != 16'hFFFF);
    end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_spi_cache_ctrl.sv
// tb_spi_cache_ctrl: randomized reads against a line-level cache model backed by a flash content function.
module tb_spi_cache_ctrl;
  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        req_valid = 1'b0, flush = 1'b0, fill_ack = 1'b0, fill_valid = 1'b0;
  logic [23:0] req_addr = '0;
  logic [15:0] fill_data = '0;
  logic        req_ready, rsp_valid, fill_req, RAM_EN;
  logic [15:0] rsp_data, RAM_DI, RAM_DO, hit_count, miss_count;
  logic [23:0] fill_addr;
  logic [1:0]  RAM_WE;
  logic [7:0]  RAM_A;
  logic [15:0] mem [256];

  always #5 CLK = ~CLK;

  spi_cache_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flush(flush),
    .fill_req(fill_req), .fill_ack(fill_ack), .fill_addr(fill_addr),
    .fill_valid(fill_valid), .fill_data(fill_data),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always @(posedge CLK)
    if (RAM_EN) begin
      if (RAM_WE == 2'b11) mem[RAM_A] <= RAM_DI;
      else RAM_DO <= mem[RAM_A];
    end

  int checks = 0, errors = 0;
  bit          mvalid [32];
  logic [14:0] mtag [32];
  bit          pend;
  int          mhits, mmiss;
  bit          last_miss;
  logic [23:0] last_fill_addr;
  logic [7:0]  first_wr_a, last_wr_a;
  logic [15:0] last_rsp;
  logic [4:0]  ipool [4] = '{5'h00, 5'h01, 5'h12, 5'h1f};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] fword(input logic [23:0] line, input int w);
    logic [15:0] h;
    if (line == 24'h000120) return 16'hA000 + 16'(w);
    h = line[19:4] * 16'h9E37 ^ 16'(w) * 16'h1357;
    return h ^ 16'h5A5A;
  endfunction

  task automatic model_reset();
    mvalid = '{default: 0};
    pend = 0;
    mhits = 0;
    mmiss = 0;
  endtask

  task automatic tick();
    @(negedge CLK);
    req_valid = 0; flush = 0; fill_ack = 0; fill_valid = 0;
  endtask

  task automatic check_reset();
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_fill_req", 32'(fill_req), 0);
    chk("rst_fill_addr", 32'(fill_addr), 0);
    chk("rst_ram_en", 32'(RAM_EN), 0);
    chk("rst_ram_we", 32'(RAM_WE), 0);
    chk("rst_ram_a", 32'(RAM_A), 0);
    chk("rst_ram_di", 32'(RAM_DI), 0);
    chk("rst_hit_count", 32'(hit_count), 0);
    chk("rst_miss_count", 32'(miss_count), 0);
  endtask

  task automatic do_read(input logic [23:0] a, input int ack_dly, input int gap34, input int gmax,
                         input int flush_at, input bit flush_idle, input int rst_at);
    logic [4:0]  idx;
    logic [14:0] tg;
    logic [23:0] line;
    logic [15:0] exp;
    int          c, nwr;
    bit          hit;
    idx = a[8:4]; tg = a[23:9]; line = {a[23:4], 4'h0};
    exp = fword(line, int'(a[3:1]));
    tick();
    req_valid = 1; req_addr = a; flush = flush_idle;
    fill_valid = 1'($urandom); fill_ack = 1'($urandom);
    #1;
    chk("rsp_single_pulse", 32'(rsp_valid), 0);
    chk("ram_idle", 32'(RAM_EN), 0);
    if (pend || flush_idle) begin
      chk("ready_during_flush", 32'(req_ready), 0);
      mvalid = '{default: 0};
      pend = 0;
      tick();
      req_valid = 1; req_addr = a;
      #1;
    end
    chk("req_ready", 32'(req_ready), 1);
    hit = mvalid[idx] && mtag[idx] == tg;
    tick();
    fill_ack = 1'($urandom);
    #1;
    chk("lookup_ram_en", 32'(RAM_EN), 1);
    chk("lookup_ram_we", 32'(RAM_WE), 0);
    chk("lookup_ram_a", 32'(RAM_A), 32'(a[8:1]));
    chk("lookup_rsp_valid", 32'(rsp_valid), 0);
    chk("lookup_fill_req", 32'(fill_req), 0);
    if (hit) begin
      mhits++;
      last_miss = 0;
      tick(); #1;
      chk("hit_rsp_valid", 32'(rsp_valid), 1);
      chk("hit_rsp_data", 32'(rsp_data), 32'(exp));
      chk("hit_no_fill_req", 32'(fill_req), 0);
      chk("hit_ram_en", 32'(RAM_EN), 0);
    end else begin
      mmiss++;
      mvalid[idx] = 0;
      last_miss = 1;
      tick(); #1;
      chk("miss_fill_req", 32'(fill_req), 1);
      chk("miss_fill_addr", 32'(fill_addr), 32'(line));
      chk("miss_rsp_valid", 32'(rsp_valid), 0);
      last_fill_addr = fill_addr;
      repeat (ack_dly) begin
        tick();
        fill_valid = 1'($urandom);
        #1;
        chk("fill_req_held", 32'(fill_req), 1);
        chk("no_write_before_ack", 32'(RAM_EN), 0);
      end
      tick();
      fill_ack = 1;
      #1;
      chk("fill_req_at_ack", 32'(fill_req), 1);
      c = 0; nwr = 0;
      for (int w = 0; w < 8; w++) begin
        int g;
        g = (w == 4) ? gap34 : $urandom_range(0, gmax);
        for (int k = 0; k <= g; k++) begin
          tick();
          if (c == flush_at) begin flush = 1; pend = 1; end
          if (k == g) begin fill_valid = 1; fill_data = fword(line, w); end
          else fill_ack = 1'($urandom);
          #1;
          if (k == g && w == rst_at) begin
            flush = 0;
            #1 RST_N = 0;
            #1 check_reset();
            tick();
            RST_N = 1;
            model_reset();
            return;
          end
          chk("fill_req_dropped", 32'(fill_req), 0);
          chk("fill_rsp_valid", 32'(rsp_valid), 0);
          if (RAM_EN && RAM_WE == 2'b11) nwr++;
          if (k == g) begin
            chk("fill_ram_en", 32'(RAM_EN), 1);
            chk("fill_ram_we", 32'(RAM_WE), 3);
            chk("fill_ram_a", 32'(RAM_A), 32'({idx, w[2:0]}));
            chk("fill_ram_di", 32'(RAM_DI), 32'(fill_data));
            if (w == 0) first_wr_a = RAM_A;
            last_wr_a = RAM_A;
          end else
            chk("gap_ram_en", 32'(RAM_EN), 0);
          c++;
        end
      end
      chk("fill_write_count", nwr, 8);
      mvalid[idx] = 1;
      mtag[idx] = tg;
      tick(); #1;
      chk("reread_ram_en", 32'(RAM_EN), 1);
      chk("reread_ram_we", 32'(RAM_WE), 0);
      chk("reread_ram_a", 32'(RAM_A), 32'(a[8:1]));
      chk("reread_rsp_valid", 32'(rsp_valid), 0);
      tick(); #1;
      chk("miss_rsp_valid_f2", 32'(rsp_valid), 1);
      chk("miss_rsp_data", 32'(rsp_data), 32'(exp));
    end
    last_rsp = rsp_data;
`ifdef CACHE_STATS_EN
    chk("hit_count", 32'(hit_count), mhits);
    chk("miss_count", 32'(miss_count), mmiss);
`else
    chk("hit_count_tied", 32'(hit_count), 0);
    chk("miss_count_tied", 32'(miss_count), 0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run still active at %0t", $time);
    $fatal(1);
  end

  initial begin
    model_reset();
    #12 check_reset();
    @(negedge CLK);
    RST_N = 1;
    do_read(24'h000124, 3, 0, 0, -1, 0, -1);
    chk("cold_miss", 32'(last_miss), 1);
    chk("cold_fill_addr", 32'(last_fill_addr), 32'h000120);
    chk("cold_first_wr", 32'(first_wr_a), 32'h90);
    chk("cold_last_wr", 32'(last_wr_a), 32'h97);
    chk("cold_rsp", 32'(last_rsp), 32'hA002);
    do_read(24'h00012E, 0, 0, 0, -1, 0, -1);
    chk("hit_seen", 32'(last_miss), 0);
    chk("hit_word7", 32'(last_rsp), 32'hA007);
    do_read(24'h000324, 1, 0, 1, -1, 0, -1);
    chk("conflict_miss", 32'(last_miss), 1);
    do_read(24'h000124, 0, 0, 0, -1, 0, -1);
    chk("evicted_miss", 32'(last_miss), 1);
    chk("evicted_rsp", 32'(last_rsp), 32'hA002);
    do_read(24'h000325, 2, 0, 1, 3, 0, -1);
    chk("flush_fill_miss", 32'(last_miss), 1);
    do_read(24'h000325, 0, 0, 0, -1, 0, -1);
    chk("after_flush_miss", 32'(last_miss), 1);
    do_read(24'h000126, 1, 2, 0, -1, 0, -1);
    chk("gap_fill_rsp", 32'(last_rsp), 32'hA003);
    do_read(24'h000126, 0, 0, 0, -1, 1, -1);
    chk("idle_flush_miss", 32'(last_miss), 1);
    do_read(24'h000524, 1, 0, 0, -1, 0, 3);
    do_read(24'h00012A, 0, 0, 0, -1, 0, -1);
    chk("post_reset_miss", 32'(last_miss), 1);
    chk("post_reset_rsp", 32'(last_rsp), 32'hA005);
    for (int i = 0; i < 60; i++) begin
      logic [23:0] a;
      a = {15'($urandom_range(0, 2)), ipool[$urandom_range(0, 3)], 3'($urandom), 1'($urandom)};
      do_read(a, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
              ($urandom_range(0, 4) == 0) ? $urandom_range(0, 8) : -1,
              $urandom_range(0, 7) == 0, -1);
    end
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_cache_ctrl.md
# spi_cache_ctrl

Direct-mapped read-cache controller that drives the 256×16 cache data SRAM port as initiator and refills lines from the SPI flash fetch engine. It sits between the CPU-side read bus and both the data RAM and the SPI master. It holds tags and valid bits in flops, checks for hits, streams 8-word line fills into the RAM, and returns the requested 16-bit word.

## Interface
- `LINES`, 32: number of cache lines; each line holds 8 words of 16 bits, 256 RAM words in total.
- `AW`, 24: byte-address width of the request and fill buses.
- `CLK` in 1: single clock; every flop is on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `req_valid` in 1 / `req_ready` out 1 / `req_addr` in AW: read request, valid/ready handshake. `req_addr[0]` is ignored.
- `rsp_valid` out 1 / `rsp_data` out 16: one-cycle response pulse. There is no backpressure.
- `flush` in 1: single-cycle pulse that invalidates all lines.
- `fill_req` out 1 / `fill_ack` in 1 / `fill_addr` out AW: line-fill request, 4-phase-free req/ack handshake.
- `fill_valid` in 1 / `fill_data` in 16: fill word stream.
- `RAM_EN` out 1, `RAM_WE` out 2, `RAM_A` out 8, `RAM_DI` out 16, `RAM_DO` in 16: data-RAM port. Read data appears on `RAM_DO` on the cycle after `RAM_EN`.
- `hit_count` out 16, `miss_count` out 16: statistics outputs (see Configuration).

## Operation
- **Address split:** offset = `req_addr[3:1]`, index = `req_addr[8:4]`, tag = `req_addr[23:9]` (15 bits). RAM address = {index, offset}.
- **States:** IDLE, LOOKUP, RESP, FILL_REQ, FILL, REREAD.
- **IDLE:**
  - `req_ready`=1 unless a flush is pending or `flush` is asserted.
  - On accept: latch the address, assert `RAM_EN` with `RAM_WE`=0 at {index, offset}, go to LOOKUP.
- **LOOKUP:**
  - Hit (valid[index] and tag match): go to RESP.
  - Miss: clear valid[index], go to FILL_REQ.
- **RESP:** `rsp_valid`=1 with `rsp_data`=`RAM_DO`, then go to IDLE.
- **FILL_REQ:**
  - Hold `fill_req`=1 with `fill_addr` = {tag, index, 4'b0}.
  - On `fill_ack`: drop `fill_req` in the next cycle, clear the word counter, go to FILL.
- **FILL:**
  - For each cycle with `fill_valid`: `RAM_EN`=1, `RAM_WE`=2'b11, `RAM_A`={index, cnt}, `RAM_DI`=`fill_data`, cnt++.
  - Gaps in `fill_valid` are waited out.
  - After word 7: set tag[index] and valid[index], go to REREAD.
- **REREAD:** `RAM_EN`=1 read at {index, offset}, then go to RESP.
- **Unexpected fill inputs:** `fill_valid` or `fill_ack` outside FILL / FILL_REQ is ignored.
- **Flush:**
  - In IDLE, `flush` clears every valid bit in one cycle and takes priority over a simultaneous `req_valid`; `req_ready`=0 that cycle.
  - A flush seen in any other state sets a pending flag, which is applied on the first IDLE cycle.
  - A line filled during that pending window is still invalidated.
- **RAM port when idle:** outside the cases above, `RAM_EN`=0 and `RAM_WE`=0.

## Timing
- **Reset values:** state=IDLE, all valid bits 0, counters 0. `req_ready`=1. `rsp_valid`, `fill_req`, `RAM_EN` and `RAM_WE` are 0. `rsp_data`, `fill_addr`, `RAM_A` and `RAM_DI` are 0.
- **Hit:** request accepted in cycle N gives `rsp_valid` in cycle N+2. Throughput is one request per 3 cycles.
- **Miss:** `fill_req` rises in cycle N+2. After the 8th fill word is written in cycle F, REREAD runs in F+1 and `rsp_valid` asserts in F+2.
- **Reset during a fill:** the line stays invalid, `fill_req` drops immediately, and the partial RAM contents are don't-care.

## Configuration
- `CACHE_STATS_EN` defined:
  - `hit_count` increments on each LOOKUP hit.
  - `miss_count` increments on each LOOKUP miss.
  - Both are 16-bit and saturate at 16'hFFFF; reset clears them; `flush` does not.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- **`cache_pkg`** holds:
  - the state enum `cache_state_t`;
  - the widths `TAG_W`=15, `IDX_W`=5, `OFF_W`=3;
  - the typedef `cache_addr_t`, a packed struct {tag, index, offset, byte}.
- **`cache_tag_store`** is the one sub-module. It holds the LINES×(TAG_W+1) flop array and provides:
  - a combinational hit compare;
  - a single-line write port;
  - clear-all.

## Test plan
- **Reset:** drop `RST_N` mid-cycle → all outputs are at their reset values asynchronously and `req_ready`=1.
- **Cold miss:**
  - Stimulus: read 0x000124 with fill words 0xA000..0xA007 and `fill_ack` after 3 cycles.
  - Check: `fill_addr`=0x000120, RAM writes to addresses 0x90..0x97, `rsp_data`=0xA002.
- **Hit:** read 0x00012E after the cold miss → `rsp_valid` at N+2 with 0xA007, no `fill_req`.
- **Conflict miss:** read 0x000324 (index 0x12, different tag) → a new fill is issued and the 0x000124 line is evicted.
- **Flush:**
  - Stimulus: `flush` during a fill.
  - Check: the fill completes and the response is returned; the next read of the same address misses.
- **Fill stream and stats:**
  - Stimulus: `fill_valid` with a 2-cycle gap between words 3 and 4; `CACHE_STATS_EN` defined.
  - Check: exactly 8 RAM writes; `hit_count`/`miss_count` match the transaction counts.
